// File: rtl/fifo_ctrl_pkg.sv
// Shared types for the consumer head-pointer writeback path: pointer type,
// writeback FSM states and the captured writeback request.
package fifo_ctrl_pkg;

    localparam int unsigned PTR_W  = 64;
    localparam int unsigned ADDR_W = 64;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [1:0] {
        HWB_IDLE     = 2'd0,
        HWB_ISSUE    = 2'd1,
        HWB_WAIT_ACK = 2'd2
    } hwb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        ptr_t              data;
    } head_wb_req_t;

    // A batch size of zero behaves like a batch of one.
    function automatic ptr_t hwb_batch_eff(input ptr_t batch);
        return (batch == '0) ? ptr_t'(1) : batch;
    endfunction

endpackage

// File: rtl/consumer_wb_timer.sv
// Idle-flush timer: clear, load-to-one, saturating count, expiry at a limit.
// Used by consumer_head_ptr_writeback only when COHORT_HEAD_WB_TIMEOUT_EN is defined.
module consumer_wb_timer #(
    parameter int unsigned TimeoutWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic                    count_i,
    input  logic [TimeoutWidth-1:0] limit_i,
    output logic                    expired_o
);

    logic [TimeoutWidth-1:0] count_q;
    logic [TimeoutWidth-1:0] count_d;
    logic                    at_max;

    assign at_max    = &count_q;
    assign expired_o = (limit_i != '0) && (count_q == limit_i);

    // The cycle in which the head moves counts as the first idle cycle.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = TimeoutWidth'(1);
        end else if (count_i && !expired_o && !at_max) begin
            count_d = count_q + TimeoutWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/consumer_head_ptr_writeback.sv
// Coalesces consumer head-pointer advances into single outstanding writebacks.
// Optional idle-flush timer is built when COHORT_HEAD_WB_TIMEOUT_EN is defined.
module consumer_head_ptr_writeback
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned PtrWidth     = 64,
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned TimeoutWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PtrWidth-1:0]     consumer_head_ptr_i,
    input  logic                    cfg_en_i,
    input  logic [AddrWidth-1:0]    cfg_head_addr_i,
    input  logic [PtrWidth-1:0]     cfg_batch_i,
    input  logic [TimeoutWidth-1:0] cfg_timeout_i,
    input  logic                    flush_i,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [AddrWidth-1:0]    wb_addr_o,
    output logic [PtrWidth-1:0]     wb_data_o,
    input  logic                    wb_ack_i,
    output logic [PtrWidth-1:0]     published_ptr_o,
    output logic                    idle_o
);

    hwb_state_e             state_q, state_d;
    logic [PtrWidth-1:0]    snap_q, snap_d;
    logic [PtrWidth-1:0]    published_q, published_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   flush_seen_q, flush_seen_d;

    logic [PtrWidth-1:0]    delta;
    logic [PtrWidth-1:0]    batch_eff;
    logic                   pending;
    logic                   timer_expired;
    logic                   trigger;

    // Modular subtraction handles pointer wrap without extra logic.
    assign delta     = consumer_head_ptr_i - published_q;
    assign pending   = (delta != '0);
    assign batch_eff = (cfg_batch_i == '0) ? PtrWidth'(1) : cfg_batch_i;
    assign trigger   = cfg_en_i && pending &&
                       ((delta >= batch_eff) || flush_seen_q || timer_expired);

`ifdef COHORT_HEAD_WB_TIMEOUT_EN
    logic [PtrWidth-1:0] head_prev_q, head_prev_d;
    logic                idle_pending;
    logic                head_changed;

    assign idle_pending = (state_q == HWB_IDLE) && pending;
    assign head_changed = (consumer_head_ptr_i != head_prev_q);

    always_comb begin
        head_prev_d = consumer_head_ptr_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_prev_q <= '0;
        end else begin
            head_prev_q <= head_prev_d;
        end
    end

    consumer_wb_timer #(
        .TimeoutWidth(TimeoutWidth)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (!idle_pending),
        .load_i   (head_changed),
        .count_i  (1'b1),
        .limit_i  (cfg_timeout_i),
        .expired_o(timer_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^cfg_timeout_i;
    assign timer_expired  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        addr_d       = addr_q;
        published_d  = published_q;
        flush_seen_d = flush_seen_q | flush_i;
        case (state_q)
            HWB_IDLE: begin
                if (trigger) begin
                    snap_d       = consumer_head_ptr_i;
                    addr_d       = cfg_head_addr_i;
                    flush_seen_d = 1'b0;
                    state_d      = HWB_ISSUE;
                end
            end
            HWB_ISSUE: begin
                if (wb_ready_i) begin
                    state_d = HWB_WAIT_ACK;
                end
            end
            HWB_WAIT_ACK: begin
                // Acks seen in any other state are stray and dropped.
                if (wb_ack_i) begin
                    published_d = snap_q;
                    state_d     = HWB_IDLE;
                end
            end
            default: begin
                state_d = HWB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HWB_IDLE;
            snap_q       <= '0;
            addr_q       <= '0;
            published_q  <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            addr_q       <= addr_d;
            published_q  <= published_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    assign wb_valid_o      = (state_q == HWB_ISSUE);
    assign wb_addr_o       = addr_q;
    assign wb_data_o       = snap_q;
    assign published_ptr_o = published_q;
    assign idle_o          = (state_q == HWB_IDLE) && !pending;

endmodule

// File: tb/tb_consumer_head_ptr_writeback.sv
// Scoreboard bench for consumer_head_ptr_writeback; timeout checks follow
// COHORT_HEAD_WB_TIMEOUT_EN as the design does.
module tb_consumer_head_ptr_writeback;

    localparam int PW = 64;
    localparam int AW = 64;
    localparam int TW = 16;
    localparam logic [AW-1:0] ADDR_A = 64'h0000_1000_0000_0040;
    localparam logic [AW-1:0] ADDR_B = 64'h0000_2000_0000_0080;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] head;
    logic          en;
    logic [AW-1:0] cfg_addr;
    logic [PW-1:0] batch;
    logic [TW-1:0] tmo;
    logic          flush;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [PW-1:0] wb_data;
    logic          wb_ack;
    logic [PW-1:0] published;
    logic          idle;

    logic [AW+PW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    consumer_head_ptr_writeback #(
        .PtrWidth(PW), .AddrWidth(AW), .TimeoutWidth(TW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .consumer_head_ptr_i(head),
        .cfg_en_i           (en),
        .cfg_head_addr_i    (cfg_addr),
        .cfg_batch_i        (batch),
        .cfg_timeout_i      (tmo),
        .flush_i            (flush),
        .wb_valid_o         (wb_valid),
        .wb_ready_i         (wb_ready),
        .wb_addr_o          (wb_addr),
        .wb_data_o          (wb_data),
        .wb_ack_i           (wb_ack),
        .published_ptr_o    (published),
        .idle_o             (idle)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic pulse_ack();
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
    endtask

    task automatic quiet(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            at_neg();
            chk(name, {63'd0, wb_valid}, 64'd0);
            tick();
        end
    endtask

    task automatic do_reset();
        chk("missing_req", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        rst_n    = 1'b0;
        head     = '0;
        en       = 1'b1;
        cfg_addr = ADDR_A;
        batch    = 64'd4;
        tmo      = '0;
        flush    = 1'b0;
        wb_ready = 1'b1;
        wb_ack   = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: pops the scoreboard on every handshake and checks that a
    // stalled request holds valid, address and data.
    initial begin
        logic             stall_seen;
        logic [AW-1:0]    stall_addr;
        logic [PW-1:0]    stall_data;
        logic [AW+PW-1:0] e;
        stall_seen = 1'b0;
        stall_addr = '0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_seen = 1'b0;
            end else begin
                if (stall_seen) begin
                    chk("hold_valid", {63'd0, wb_valid}, 64'd1);
                    chk("hold_addr", wb_addr, stall_addr);
                    chk("hold_data", wb_data, stall_data);
                end
                stall_seen = wb_valid && !wb_ready;
                stall_addr = wb_addr;
                stall_data = wb_data;
                if (wb_valid && wb_ready) begin
                    assert (!wb_ack) else $error("ack coincides with request handshake");
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req: got data %h want no request", wb_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_addr", wb_addr, e[AW+PW-1:PW]);
                        chk("req_data", wb_data, e[PW-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        head     = '0;
        en       = 1'b1;
        cfg_addr = ADDR_A;
        batch    = 64'd4;
        tmo      = '0;
        flush    = 1'b0;
        wb_ready = 1'b1;
        wb_ack   = 1'b0;

        // Reset state and batch threshold.
        do_reset();
        at_neg();
        chk("rst_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_addr", wb_addr, 64'd0);
        chk("rst_data", wb_data, 64'd0);
        chk("rst_published", published, 64'd0);
        chk("rst_idle", {63'd0, idle}, 64'd1);
        tick();
        for (int h = 1; h <= 4; h++) begin
            head = PW'(h);
            if (h == 4) exp_q.push_back({ADDR_A, 64'd4});
            at_neg();
            chk("t1_no_early", {63'd0, wb_valid}, 64'd0);
            tick();
        end
        at_neg();
        chk("t1_valid", {63'd0, wb_valid}, 64'd1);
        tick();
        at_neg();
        chk("t1_wait_ack", {63'd0, wb_valid}, 64'd0);
        tick();
        pulse_ack();
        at_neg();
        chk("t1_published", published, 64'd4);
        chk("t1_idle", {63'd0, idle}, 64'd1);
        tick();

        // Backpressure while the head keeps moving.
        do_reset();
        wb_ready = 1'b0;
        for (int h = 1; h <= 4; h++) begin
            head = PW'(h);
            if (h == 4) exp_q.push_back({ADDR_A, 64'd4});
            tick();
        end
        at_neg();
        chk("t2_valid", {63'd0, wb_valid}, 64'd1);
        tick();
        cfg_addr = ADDR_B;
        for (int h = 5; h <= 9; h++) begin
            head = PW'(h);
            at_neg();
            chk("t2_stall_data", wb_data, 64'd4);
            chk("t2_stall_addr", wb_addr, ADDR_A);
            tick();
        end
        wb_ready = 1'b1;
        tick();
        exp_q.push_back({ADDR_B, 64'd9});
        pulse_ack();
        at_neg();
        chk("t2_published", published, 64'd4);
        chk("t2_gap", {63'd0, wb_valid}, 64'd0);
        tick();
        at_neg();
        chk("t2_second_valid", {63'd0, wb_valid}, 64'd1);
        tick();
        pulse_ack();
        at_neg();
        chk("t2_published2", published, 64'd9);
        tick();

        // Pointer wrap.
        do_reset();
        batch = 64'd3;
        head  = 64'hFFFF_FFFF_FFFF_FFFE;
        exp_q.push_back({ADDR_A, 64'hFFFF_FFFF_FFFF_FFFE});
        tick();
        at_neg();
        chk("t3_valid", {63'd0, wb_valid}, 64'd1);
        tick();
        pulse_ack();
        at_neg();
        chk("t3_published_hi", published, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        head = 64'd0;
        quiet(2, "t3_below_batch");
        head = 64'd1;
        exp_q.push_back({ADDR_A, 64'd1});
        tick();
        at_neg();
        chk("t3_wrap_valid", {63'd0, wb_valid}, 64'd1);
        tick();
        pulse_ack();
        at_neg();
        chk("t3_published_wrap", published, 64'd1);
        tick();

        // Idle timeout.
        do_reset();
        batch = 64'd8;
        tmo   = 16'd10;
        head  = 64'd1;
        tick();
        head  = 64'd2;
`ifdef COHORT_HEAD_WB_TIMEOUT_EN
        exp_q.push_back({ADDR_A, 64'd2});
        quiet(11, "t4_before_timeout");
        at_neg();
        chk("t4_timeout_valid", {63'd0, wb_valid}, 64'd1);
        tick();
        pulse_ack();
        at_neg();
        chk("t4_published", published, 64'd2);
        tick();
`else
        quiet(30, "t4_no_timer");
        at_neg();
        chk("t4_published", published, 64'd0);
        chk("t4_not_idle", {63'd0, idle}, 64'd0);
        tick();
`endif

        // Flush during WAIT_ACK, then flush with nothing pending.
        do_reset();
        batch = 64'd100;
        head  = 64'd1;
        flush = 1'b1;
        exp_q.push_back({ADDR_A, 64'd1});
        tick();
        flush = 1'b0;
        at_neg();
        chk("t5_flush_lat1", {63'd0, wb_valid}, 64'd0);
        tick();
        at_neg();
        chk("t5_flush_valid", {63'd0, wb_valid}, 64'd1);
        tick();
        head  = 64'd2;
        flush = 1'b1;
        exp_q.push_back({ADDR_A, 64'd2});
        tick();
        flush = 1'b0;
        tick();
        tick();
        pulse_ack();
        at_neg();
        chk("t5_published1", published, 64'd1);
        chk("t5_gap", {63'd0, wb_valid}, 64'd0);
        tick();
        at_neg();
        chk("t5_second_valid", {63'd0, wb_valid}, 64'd1);
        tick();
        pulse_ack();
        at_neg();
        chk("t5_published2", published, 64'd2);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        quiet(8, "t5_empty_flush");
        at_neg();
        chk("t5_idle", {63'd0, idle}, 64'd1);
        tick();

        // Reset while waiting for an ack; the late ack is dropped.
        do_reset();
        batch = 64'd1;
        head  = 64'd1;
        exp_q.push_back({ADDR_A, 64'd1});
        tick();
        at_neg();
        chk("t6_valid", {63'd0, wb_valid}, 64'd1);
        tick();
        rst_n = 1'b0;
        head  = 64'd0;
        at_neg();
        chk("t6_rst_valid", {63'd0, wb_valid}, 64'd0);
        chk("t6_rst_published", published, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        pulse_ack();
        quiet(5, "t6_no_req");
        at_neg();
        chk("t6_published", published, 64'd0);
        chk("t6_idle", {63'd0, idle}, 64'd1);
        tick();

        // Enable gating and batch of zero.
        do_reset();
        en   = 1'b0;
        head = 64'd6;
        quiet(4, "t7_disabled");
        en = 1'b1;
        exp_q.push_back({ADDR_A, 64'd6});
        at_neg();
        chk("t7_enable_lat", {63'd0, wb_valid}, 64'd0);
        tick();
        at_neg();
        chk("t7_valid", {63'd0, wb_valid}, 64'd1);
        tick();
        pulse_ack();
        at_neg();
        chk("t7_published", published, 64'd6);
        tick();
        batch = 64'd0;
        head  = 64'd7;
        exp_q.push_back({ADDR_A, 64'd7});
        tick();
        at_neg();
        chk("t7_batch0_valid", {63'd0, wb_valid}, 64'd1);
        tick();
        pulse_ack();
        at_neg();
        chk("t7_published_b0", published, 64'd7);
        tick();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
